// File: rtl/vx_burst_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vx_burst_rr_arbiter
//  Description : Round-robin arbiter for multi-beat bursts. Selection is a
//                rotating mask plus a lowest-index priority encode. The grant
//                locks to a requester from its first accepted beat until its
//                last beat, so bursts never interleave.
//                Optional macro VX_ARB_BURST_LIMIT_EN forces a lock release
//                after MAX_BURST accepted beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_burst_rr_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int MAX_BURST    = 16,
    parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQS-1:0]     requests,
    input  logic [NUM_REQS-1:0]     req_last,
    output logic                    grant_valid,
    output logic [LOG_NUM_REQS-1:0] grant_index,
    output logic [NUM_REQS-1:0]     grant_onehot,
    input  logic                    grant_ready
);

    // Elaboration-time parameter sanity checks
    if ((NUM_REQS < 1) || (NUM_REQS > 32)) begin : g_bad_num_reqs
        $error("NUM_REQS must be in 1..32");
    end
    if (MAX_BURST < 2) begin : g_bad_max_burst
        $error("MAX_BURST must be at least 2");
    end

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;
    localparam logic [LOG_NUM_REQS-1:0] c_LAST_IDX = LOG_NUM_REQS'(NUM_REQS - 1);

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [LOG_NUM_REQS-1:0] r_ptr;
    logic [LOG_NUM_REQS-1:0] w_ptr_nxt;
    logic [LOG_NUM_REQS-1:0] r_lock_idx;
    logic [LOG_NUM_REQS-1:0] w_lock_idx_nxt;

    logic [LOG_NUM_REQS-1:0] w_winner;
    logic                    w_rr_found;
    logic [LOG_NUM_REQS-1:0] w_rr_idx;
    logic                    w_lo_found;
    logic [LOG_NUM_REQS-1:0] w_lo_idx;
    logic [LOG_NUM_REQS-1:0] w_ptr_after;
    logic                    w_fire;
    logic                    w_last;
    logic                    w_release;

`ifdef VX_ARB_BURST_LIMIT_EN
    localparam int c_BEAT_W = $clog2(MAX_BURST) + 1;
    logic [c_BEAT_W-1:0] r_beat_cnt;
    logic [c_BEAT_W-1:0] w_beat_cnt_nxt;
`endif

    // IDLE selection: first request at or above ptr, else lowest request overall
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (requests[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = LOG_NUM_REQS'(i);
            end
            if (requests[i] && !w_rr_found && (i >= int'(r_ptr))) begin
                w_rr_found = 1'b1;
                w_rr_idx   = LOG_NUM_REQS'(i);
            end
        end
        w_winner = w_rr_found ? w_rr_idx : w_lo_idx;
    end

    // Grant outputs: locked requester overrides arbitration; depends only on
    // requests and registered state, never on grant_ready
    always_comb begin
        if (r_state == c_LOCKED) begin
            grant_index = r_lock_idx;
            grant_valid = requests[r_lock_idx];
        end else begin
            grant_index = w_winner;
            grant_valid = |requests;
        end
        grant_onehot = grant_valid ? (NUM_REQS'(1) << grant_index) : '0;
        w_fire       = grant_valid && grant_ready;
        w_last       = req_last[grant_index];
        w_ptr_after  = (grant_index == c_LAST_IDX) ? '0 : grant_index + LOG_NUM_REQS'(1);
    end

    // Lock release: last beat, or (optionally) the beat limit being reached
    always_comb begin
`ifdef VX_ARB_BURST_LIMIT_EN
        w_release = w_last || (r_beat_cnt == c_BEAT_W'(MAX_BURST - 1));
`else
        w_release = w_last;
`endif
    end

    // Next-state logic for the lock FSM and round-robin pointer
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_lock_idx_nxt = r_lock_idx;
`ifdef VX_ARB_BURST_LIMIT_EN
        w_beat_cnt_nxt = r_beat_cnt;
`endif
        case (r_state)
            c_IDLE: begin
                if (w_fire) begin
                    if (w_last) begin
                        w_ptr_nxt = w_ptr_after;
                    end else begin
                        w_state_nxt    = c_LOCKED;
                        w_lock_idx_nxt = grant_index;
`ifdef VX_ARB_BURST_LIMIT_EN
                        w_beat_cnt_nxt = c_BEAT_W'(1);
`endif
                    end
                end
            end
            c_LOCKED: begin
                if (w_fire) begin
                    if (w_release) begin
                        w_state_nxt = c_IDLE;
                        w_ptr_nxt   = w_ptr_after;
`ifdef VX_ARB_BURST_LIMIT_EN
                        w_beat_cnt_nxt = '0;
`endif
                    end else begin
`ifdef VX_ARB_BURST_LIMIT_EN
                        w_beat_cnt_nxt = r_beat_cnt + c_BEAT_W'(1);
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_ptr      <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end

`ifdef VX_ARB_BURST_LIMIT_EN
    // Beat counter for the forced-release limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt <= '0;
        end else begin
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/vx_burst_rr_arbiter.md
# vx_burst_rr_arbiter

Round-robin arbiter that shares one downstream port among `NUM_REQS` requesters whose transfers are multi-beat bursts. Priority selection is a rotating mask followed by a lowest-index priority encode. Once a burst's first beat is accepted, the grant locks to that requester until its `last` beat. Used in front of shared memory and bus ports where beats of different bursts must never interleave.

## Interface
- `NUM_REQS`, 4: number of requesters; legal range is 1 to 32.
- `MAX_BURST`, 16: beat limit before a forced release. Used only when `VX_ARB_BURST_LIMIT_EN` is defined. Must be at least 2.
- `LOG_NUM_REQS`, `LOG2UP(NUM_REQS)`: index width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `requests`  in  NUM_REQS  per-requester valid.
- `req_last`  in  NUM_REQS  per-requester "this beat ends the burst".
- `grant_valid`  out  1  a granted requester is presenting a beat.
- `grant_index`  out  LOG_NUM_REQS  index of the granted requester.
- `grant_onehot`  out  NUM_REQS  one-hot form of `grant_index`; all-zero when `grant_valid`=0.
- `grant_ready`  in  1  downstream accepts the beat. A handshake (`fire`) occurs when `grant_valid && grant_ready`.

## Operation
- State:
  - `ptr`: LOG_NUM_REQS-bit round-robin pointer.
  - `state`: IDLE or LOCKED.
  - `lock_idx`: LOG_NUM_REQS bits.
  - `beat_cnt`: `LOG2UP(MAX_BURST)+1` bits; present only when the macro is defined.
- Reset values: `ptr`=0, `state`=IDLE, `lock_idx`=0, `beat_cnt`=0.
- Outputs during and immediately after reset, with `requests`=0: `grant_valid`=0, `grant_index`=0, `grant_onehot`=0.
- IDLE selection:
  - `masked` = the bits of `requests` at positions >= `ptr`.
  - If `masked` is nonzero, the winner is the lowest set bit of `masked`; otherwise it is the lowest set bit of `requests`.
  - `grant_valid` = OR of `requests`.
  - When no request is set, `grant_index`=0.
- IDLE, `fire` with `req_last[winner]`=1 (single-beat burst):
  - Stay IDLE.
  - `ptr` <= winner+1, wrapping to 0 when winner = NUM_REQS-1.
- IDLE, `fire` with `req_last[winner]`=0:
  - Go to LOCKED.
  - `lock_idx` <= winner; `beat_cnt` <= 1.
  - `ptr` is unchanged.
- LOCKED:
  - `grant_index` = `lock_idx`, regardless of other requests.
  - `grant_valid` = `requests[lock_idx]`.
  - If the locked requester deasserts, `grant_valid` falls to 0 and the lock holds; no other requester is granted.
- LOCKED, `fire` with `req_last[lock_idx]`=1:
  - Go to IDLE.
  - `ptr` <= `lock_idx`+1, wrapping.
  - `beat_cnt` <= 0.
- LOCKED, `fire` without last: `beat_cnt` increments.
- `req_last` is sampled only on `fire`, and only for the granted index.
- With NUM_REQS=1: `grant_index` is constant 0; `ptr` is constant 0.

## Timing
- The grant is combinational from `requests` and the registered state: zero-cycle latency from request to grant.
- `ptr`, `state` and the lock update at the edge where `fire` is high. The new grant is visible in the next cycle.
- After an IDLE-to-IDLE transition at edge k, a different requester can be granted in cycle k+1. There are no bubble cycles.
- `grant_ready` may be high without `grant_valid`; this has no effect.
- `reset_n` asserted mid-burst clears the lock immediately (asynchronously). The first cycle after reset deassertion arbitrates from `ptr`=0.
- No combinational path from `grant_ready` to `grant_valid`, `grant_index` or `grant_onehot`.

## Configuration
- `VX_ARB_BURST_LIMIT_EN` defined:
  - In LOCKED, a `fire` at which `beat_cnt` = MAX_BURST-1 forces a transition to IDLE, even when `req_last`=0.
  - `ptr` <= `lock_idx`+1, wrapping.
  - The remaining beats of that burst re-arbitrate as a new burst.
  - This bounds starvation to MAX_BURST beats per competing requester.
- Not defined:
  - `beat_cnt` is not instantiated.
  - The lock is released only by `req_last`.

## Test plan
- Reset mid-burst (NUM_REQS=4): lock req 2 with a non-last beat, then pulse `reset_n`=0 asynchronously between edges, with `requests`=4'b0101. Required: the grant drops immediately to idx 0 (`ptr`=0); the lock is gone.
- Round-robin rotation: hold `requests`=4'b1111, `req_last`=4'b1111, `grant_ready`=1 for 6 cycles. Required: `grant_index` sequence 0,1,2,3,0,1; `grant_onehot` is 0001, 0010, 0100, 1000, ...
- Burst lock: req 1 sends 3 beats (last on the third) while req 0 and req 3 also request. Required: `grant_index`=1 for all 3 beats, then 3, then 0.
- Lock hold with gap: req 2 is locked after 1 beat, then drops `requests[2]` for 2 cycles while req 0 requests. Required: `grant_valid`=0 and `grant_index`=2 during the gap; req 2 resumes and finishes; only then req 0 is granted.
- Backpressure: `grant_ready`=0 for 3 cycles with req 3 alone and `req_last`=0. Required: `grant_index` stable at 3 and `state` stays IDLE until the first `fire`.
- Burst limit (macro defined, MAX_BURST=4): req 0 streams with `req_last`=0 while req 1 requests. Required: grant switches to req 1 after exactly 4 accepted beats of req 0.
